// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus controller.
package lcd_pkg;

    // Request operation codes presented on OPER
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_CHAR  = 2'b01;
    localparam logic [1:0] OP_INSTR = 2'b10;
    localparam logic [1:0] OP_RESET = 2'b11;

    // HD44780 instruction bytes used by the controller
    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] ENTRY_N       = 8'h06;
    localparam logic [7:0] HOME          = 8'h02;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } state_e;

    // Power-on init sequence, entry 0 is written first
    localparam int unsigned INIT_LEN = 6;
    localparam int unsigned IDX_W    = 3;
    localparam logic [INIT_LEN-1:0][7:0] INIT_SEQ = {
        ENTRY_N, CLEAR, DISP_ON, FUNC_SET_8B2L, FUNC_SET_8B2L, FUNC_SET_8B2L
    };

    // One bus write: register select, data byte, and which execution wait follows
    typedef struct packed {
        logic       rs;
        logic [7:0] db;
        logic       long_wait;
    } lcd_cmd_t;

    // Clear (0x01) and home (0x02/0x03) need the long execution wait
    function automatic logic is_long_cmd(input logic [7:0] b);
        return (b[7:2] == 6'd0) && (b != 8'd0);
    endfunction

endpackage

// File: rtl/lcd_bus_ctrl_if.sv
// Request handshake from the message sequencer plus the LCD parallel bus.
interface lcd_bus_ctrl_if;
    logic [7:0] DATA;
    logic [1:0] OPER;
    logic       ENB;
    logic       LCD_RDY;
    logic       INIT_DONE;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;
    logic [7:0] LCD_DB;

    modport master (
        output DATA, OPER, ENB,
        input  LCD_RDY, INIT_DONE, LCD_RS, LCD_RW, LCD_E, LCD_DB
    );

    modport slave (
        input  DATA, OPER, ENB,
        output LCD_RDY, INIT_DONE, LCD_RS, LCD_RW, LCD_E, LCD_DB
    );
endinterface

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by all timed controller states.
// Loading N-1 on state entry makes done rise after exactly N cycles.
module lcd_delay_timer #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q;

    // Next count: load wins, otherwise decrement and stick at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter and registered zero flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= (cnt_d == '0);
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/lcd_bus_ctrl.sv
// HD44780 8-bit bus responder: power-on init, request capture, E timing.
module lcd_bus_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_AS    = 4,
    parameter int unsigned T_PW    = 12,
    parameter int unsigned T_H     = 4,
    parameter int unsigned T_SHORT = 2100,
    parameter int unsigned T_LONG  = 82000,
    parameter int unsigned CNT_W   = 20
) (
    input logic           CLK,
    input logic           RST,
    lcd_bus_ctrl_if.slave lcd
);

    // The reset-release cycle is itself the first power-up cycle, hence -2
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 2);
    localparam logic [CNT_W-1:0] LD_AS    = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] LD_H     = CNT_W'(T_H - 1);
    localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(T_SHORT - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);

    state_e           state_q, state_d;
    lcd_cmd_t         cmd_q, cmd_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             init_done_q, init_done_d;
    logic             arm_q, arm_d;
    logic             enb_q;
    logic             rdy_q, rdy_d;
    logic             e_q, e_d;
    logic             capture_c;
    logic             tmr_load_c;
    logic [CNT_W-1:0] tmr_val_c;
    logic             tmr_done;

    lcd_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (CLK),
        .rst     (RST),
        .load_i  (tmr_load_c),
        .value_i (tmr_val_c),
        .done_o  (tmr_done)
    );

    // Next state, timer loads and bus command selection
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        arm_d       = arm_q;
        tmr_load_c  = 1'b0;
        tmr_val_c   = '0;
        capture_c   = lcd.ENB && enb_q && rdy_q && (lcd.OPER != OP_NONE);

        case (state_q)
            ST_PWRUP: begin
                if (arm_q) begin
                    arm_d      = 1'b0;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = LD_PWRUP;
                end else if (tmr_done) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                cmd_d.rs        = 1'b0;
                cmd_d.db        = INIT_SEQ[idx_q];
                cmd_d.long_wait = is_long_cmd(INIT_SEQ[idx_q]);
                state_d         = ST_SETUP;
                tmr_load_c      = 1'b1;
                tmr_val_c       = LD_AS;
            end
            ST_IDLE: begin
                if (capture_c) begin
                    tmr_load_c = 1'b1;
                    if (lcd.OPER == OP_RESET) begin
                        init_done_d = 1'b0;
                        idx_d       = '0;
                        state_d     = ST_PWRUP;
                        tmr_val_c   = LD_SHORT;
                    end else begin
                        cmd_d.rs        = (lcd.OPER == OP_CHAR);
                        cmd_d.db        = lcd.DATA;
                        cmd_d.long_wait = (lcd.OPER == OP_INSTR) && is_long_cmd(lcd.DATA);
                        state_d         = ST_SETUP;
                        tmr_val_c       = LD_AS;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d    = ST_PULSE;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = LD_PW;
                end
            end
            ST_PULSE: begin
                if (tmr_done) begin
                    state_d    = ST_HOLD;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = LD_H;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    state_d    = ST_EXEC;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = cmd_q.long_wait ? LD_LONG : LD_SHORT;
                end
            end
            ST_EXEC: begin
                if (tmr_done) begin
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == IDX_W'(INIT_LEN - 1)) begin
                        init_done_d = 1'b1;
                        idx_d       = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_INIT;
                    end
                end
            end
            default: begin
                state_d = ST_PWRUP;
            end
        endcase

        // Ready only on settled IDLE cycles; drops the cycle after a capture
        rdy_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
        e_d   = (state_d == ST_PULSE);
    end

    // State and output registers; reset kills any E pulse immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_PWRUP;
            cmd_q       <= '0;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            arm_q       <= 1'b1;
            enb_q       <= 1'b0;
            rdy_q       <= 1'b0;
            e_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            arm_q       <= arm_d;
            enb_q       <= lcd.ENB;
            rdy_q       <= rdy_d;
            e_q         <= e_d;
        end
    end

    assign lcd.LCD_RDY   = rdy_q;
    assign lcd.INIT_DONE = init_done_q;
    assign lcd.LCD_RS    = cmd_q.rs;
    assign lcd.LCD_RW    = 1'b0;
    assign lcd.LCD_E     = e_q;
    assign lcd.LCD_DB    = cmd_q.db;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Bench for lcd_bus_ctrl: E-pulse scoreboard plus table of single requests.
`timescale 1ns/1ps
module tb_lcd_bus_ctrl;
    import lcd_pkg::*;

    localparam int unsigned P_PWRUP = 20;
    localparam int unsigned P_AS    = 2;
    localparam int unsigned P_PW    = 3;
    localparam int unsigned P_H     = 2;
    localparam int unsigned P_SHORT = 8;
    localparam int unsigned P_LONG  = 30;
    localparam int unsigned INIT_TOTAL = 6 * (1 + P_AS + P_PW + P_H) + 5 * P_SHORT + P_LONG;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_bus_ctrl_if lcd();

    lcd_bus_ctrl #(
        .T_PWRUP (P_PWRUP),
        .T_AS    (P_AS),
        .T_PW    (P_PW),
        .T_H     (P_H),
        .T_SHORT (P_SHORT),
        .T_LONG  (P_LONG),
        .CNT_W   (20)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .lcd (lcd)
    );

    typedef struct {
        logic        rs;
        logic [7:0]  db;
        int unsigned w;
        logic        to_idle;
    } exp_t;

    // kind: 0 ignored request, 1 bus write, 2 re-initialise
    typedef struct {
        logic [1:0]  oper;
        logic [7:0]  data;
        int          kind;
        logic        rs;
        int unsigned w;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    // Monitor: checks every E pulse against the scoreboard and the gap after it
    logic        e_prev, rdy_prev, in_pulse, gap_armed, exp_rdy_evt, have_cur;
    int unsigned width, gap, exp_gap;
    exp_t        cur;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            in_pulse    = 1'b0;
            have_cur    = 1'b0;
            gap         = 0;
            gap_armed   = 1'b1;
            exp_rdy_evt = 1'b0;
            exp_gap     = P_PWRUP + 1 + P_AS;
            e_prev      = 1'b0;
            rdy_prev    = 1'b0;
        end else begin
            if (lcd.LCD_E && !e_prev) begin
                if (gap_armed) begin
                    check("event_is_rdy", 0, longint'(exp_rdy_evt));
                    check("gap_before_E", gap, exp_gap);
                    gap_armed = 1'b0;
                end
                pulses++;
                check("sb_nonempty", longint'(sb.size() > 0), 1);
                have_cur = (sb.size() > 0);
                if (have_cur) begin
                    cur = sb.pop_front();
                    check("pulse_rs", lcd.LCD_RS, cur.rs);
                    check("pulse_db", lcd.LCD_DB, cur.db);
                end
                check("pulse_rw", lcd.LCD_RW, 0);
                in_pulse = 1'b1;
                width    = 1;
            end else if (lcd.LCD_E && in_pulse) begin
                width++;
            end else if (!lcd.LCD_E && e_prev) begin
                check("e_width", width, P_PW);
                in_pulse = 1'b0;
                gap      = 1;
                if (have_cur) begin
                    gap_armed   = 1'b1;
                    exp_rdy_evt = cur.to_idle;
                    exp_gap     = cur.to_idle ? cur.w + 3 : cur.w + 5;
                end
            end else if (lcd.LCD_RDY && !rdy_prev) begin
                if (gap_armed) begin
                    check("event_is_rdy", 1, longint'(exp_rdy_evt));
                    check("gap_before_rdy", gap, exp_gap);
                    gap_armed = 1'b0;
                end
            end else if (!lcd.LCD_E) begin
                gap++;
            end
            e_prev   = lcd.LCD_E;
            rdy_prev = lcd.LCD_RDY;
        end
    end

    task automatic push_init();
        logic [7:0] init_bytes [6];
        init_bytes = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{rs: 1'b0, db: init_bytes[i],
                           w: (i == 4) ? P_LONG : P_SHORT, to_idle: (i == 5)});
        end
    endtask

    // Counts negedges with LCD_RDY low until it rises (bounded)
    task automatic count_rdy_low(input string name, input int unsigned exp_n);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (lcd.LCD_RDY) break;
            n++;
        end
        check(name, n, exp_n);
    endtask

    task automatic wait_rdy_level(input logic lvl, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (lcd.LCD_RDY == lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int p0;
        p0 = pulses;
        @(posedge clk); #1;
        lcd.OPER = v.oper;
        lcd.DATA = v.data;
        lcd.ENB  = 1'b1;
        if (v.kind == 1) sb.push_back('{rs: v.rs, db: v.data, w: v.w, to_idle: 1'b1});
        @(posedge clk);
        @(posedge clk); #1;
        lcd.ENB  = 1'b0;
        lcd.OPER = OP_NONE;
        if (v.kind == 1) begin
            count_rdy_low("req_rdy_low", v.w + P_AS + P_PW + P_H + 1);
            check("req_pulse_count", pulses - p0, 1);
        end else if (v.kind == 2) begin
            @(negedge clk);
            check("reinit_done_low", lcd.INIT_DONE, 0);
            push_init();
            count_rdy_low("reinit_rdy_low", P_SHORT + INIT_TOTAL);
            check("reinit_done_high", lcd.INIT_DONE, 1);
            check("reinit_pulse_count", pulses - p0, 6);
        end else begin
            repeat (6) @(negedge clk);
            check("none_rdy_high", lcd.LCD_RDY, 1);
            check("none_no_pulse", pulses - p0, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [10];
        logic [7:0] stream [5];
        logic       ok;
        int         p0;

        vecs[0] = '{OP_CHAR,  8'h52, 1, 1'b1, P_SHORT};
        vecs[1] = '{OP_INSTR, HOME,  1, 1'b0, P_LONG};
        vecs[2] = '{OP_INSTR, 8'h0C, 1, 1'b0, P_SHORT};
        vecs[3] = '{OP_NONE,  8'h41, 0, 1'b0, 0};
        vecs[4] = '{OP_INSTR, 8'h01, 1, 1'b0, P_LONG};
        vecs[5] = '{OP_INSTR, 8'h00, 1, 1'b0, P_SHORT};
        vecs[6] = '{OP_INSTR, 8'h04, 1, 1'b0, P_SHORT};
        vecs[7] = '{OP_INSTR, 8'h03, 1, 1'b0, P_LONG};
        vecs[8] = '{OP_RESET, 8'h00, 2, 1'b0, 0};
        vecs[9] = '{OP_CHAR,  8'h7E, 1, 1'b1, P_SHORT};
        stream  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h52};

        lcd.ENB  = 1'b0;
        lcd.OPER = OP_NONE;
        lcd.DATA = 8'h00;

        // Power-on: outputs quiet in reset, then the full init sequence
        repeat (3) @(posedge clk);
        #1;
        check("rst_e",    lcd.LCD_E, 0);
        check("rst_rdy",  lcd.LCD_RDY, 0);
        check("rst_done", lcd.INIT_DONE, 0);
        check("rst_db",   lcd.LCD_DB, 0);
        push_init();
        rst = 1'b0;
        count_rdy_low("pwrup_rdy_low", P_PWRUP + INIT_TOTAL + 1);
        check("pwrup_init_done", lcd.INIT_DONE, 1);
        check("pwrup_pulses", pulses, 6);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // ENB held high while a sequencer streams "1234R"
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{rs: 1'b1, db: stream[i], w: P_SHORT, to_idle: 1'b1});
        end
        @(posedge clk); #1;
        lcd.OPER = OP_CHAR;
        lcd.DATA = stream[0];
        lcd.ENB  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_rdy_level(1'b1, ok);
            check("stream_rdy_high", ok, 1);
            wait_rdy_level(1'b0, ok);
            check("stream_rdy_low", ok, 1);
            if (k < 4) begin
                lcd.DATA = stream[k+1];
            end else begin
                lcd.ENB  = 1'b0;
                lcd.OPER = OP_NONE;
            end
        end
        count_rdy_low("stream_last_rdy_low", P_SHORT + P_AS + P_PW + P_H);
        check("stream_pulses", pulses - p0, 5);

        // Reset while E is high: immediate quiet bus, then a clean restart
        @(posedge clk); #1;
        lcd.OPER = OP_CHAR;
        lcd.DATA = 8'h5A;
        lcd.ENB  = 1'b1;
        sb.push_back('{rs: 1'b1, db: 8'h5A, w: P_SHORT, to_idle: 1'b1});
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lcd.LCD_E) begin
                ok = 1'b1;
                break;
            end
        end
        check("midrst_saw_e", ok, 1);
        lcd.ENB  = 1'b0;
        lcd.OPER = OP_NONE;
        #2 rst = 1'b1;
        #1;
        check("midrst_e",    lcd.LCD_E, 0);
        check("midrst_rs",   lcd.LCD_RS, 0);
        check("midrst_db",   lcd.LCD_DB, 0);
        check("midrst_rdy",  lcd.LCD_RDY, 0);
        check("midrst_done", lcd.INIT_DONE, 0);
        p0 = pulses;
        repeat (2) @(posedge clk);
        push_init();
        #1 rst = 1'b0;
        count_rdy_low("midrst_rdy_low", P_PWRUP + INIT_TOTAL + 1);
        check("midrst_pulses", pulses - p0, 6);
        check("midrst_init_done", lcd.INIT_DONE, 1);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_ctrl.md
Name: lcd_bus_ctrl

Overview:
- Physical-side responder for the character-LCD command interface. Accepts DATA/OPER/ENB requests from the message sequencer, returns LCD_RDY, and drives an HD44780-compatible 8-bit parallel bus (RS, RW, E, DB).
- Performs the power-on initialisation sequence itself.
- Enforces E setup, pulse and hold timing plus the per-command execution delay before reporting ready again.

Parameters:
- T_PWRUP, 750000: cycles to wait after reset before the first bus write (15 ms at 50 MHz).
- T_AS, 4: cycles RS/DB are stable before E rises.
- T_PW, 12: cycles E is held high.
- T_H, 4: cycles RS/DB are held after E falls.
- T_SHORT, 2100: execution wait for normal commands and characters (42 us).
- T_LONG, 82000: execution wait for clear/home (1.64 ms).
- CNT_W, 20: delay counter width; must satisfy 2^CNT_W > max(T_PWRUP, T_LONG).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- DATA  in  8  character or instruction byte
- OPER  in  2  00 none, 01 write character, 10 write instruction, 11 re-initialise
- ENB  in  1  request valid (level)
- LCD_RDY  out  1  high when a new request can be accepted
- INIT_DONE  out  1  high once the init sequence has completed
- LCD_RS  out  1  register select (1 = data)
- LCD_RW  out  1  read/write; tied 0 (write only)
- LCD_E  out  1  enable strobe
- LCD_DB  out  8  data bus

Behaviour:
- Reset: asynchronous and active-high, per the decided interface.
  - Outputs while RST is high: all outputs 0 (LCD_E low immediately), state PWRUP, counter 0.
  - Reset mid-transfer aborts the transfer and restarts the power-up wait; no partial E pulse may follow.
- State machine: PWRUP, INIT, IDLE, SETUP, PULSE, HOLD, EXEC.
- Delay counter: loaded on state entry, counts down; the state exits in the cycle the counter reaches 0. A T_x = N wait lasts exactly N cycles.
- PWRUP: wait T_PWRUP cycles, then go to INIT.
- INIT: issues a 6-entry fixed sequence through SETUP, PULSE, HOLD, EXEC with RS=0:
  - 0x38, 0x38, 0x38 (function set, 8-bit, 2-line)
  - 0x0C (display on)
  - 0x01 (clear)
  - 0x06 (entry mode)
  - After the last entry's EXEC completes: INIT_DONE=1 and go to IDLE.
- LCD_RDY:
  - LCD_RDY=1 only in IDLE, registered.
  - LCD_RDY=0 from the cycle after capture until EXEC completes.
- Request capture occurs in a cycle where all of the following hold:
  - ENB=1
  - ENB was also 1 in the previous cycle (one-cycle settle for the sequencer's registered DATA)
  - LCD_RDY=1
  - OPER != 00
- On capture, DATA and OPER are latched; the request is consumed once.
  - ENB held high across the busy period does not re-capture the same byte until LCD_RDY returns; the byte present at that point is the next request.
- ENB=1 with OPER=00: ignored, LCD_RDY stays 1.
- OPER=01: RS=1, DB=DATA, exec wait T_SHORT.
- OPER=10: RS=0, DB=DATA.
  - Exec wait is T_LONG if DATA[7:2]==0 and DATA!=0 (clear/home), else T_SHORT.
- OPER=11: clear INIT_DONE and go to PWRUP with the counter set to T_SHORT, then rerun INIT; no bus write for the request itself.
- Bus cycle timing:
  - SETUP: T_AS cycles, RS/DB valid, E=0.
  - PULSE: T_PW cycles, E=1.
  - HOLD: T_H cycles, E=0, RS/DB unchanged.
  - EXEC: wait as above.
  - RS/DB keep their last value in IDLE.
- Request withdrawn (ENB falls) before capture: nothing is written.
- Requests during PWRUP/INIT are ignored (LCD_RDY=0).

Decomposition:
- Package lcd_pkg holds:
  - OPER codes (OP_NONE, OP_CHAR, OP_INSTR, OP_RESET)
  - instruction constants (FUNC_SET_8B2L, DISP_ON, CLEAR, ENTRY_N, HOME)
  - state encoding
  - the init sequence constant array and its length (6)
- One sub-module: lcd_delay_timer.
  - Inputs: load + value.
  - Outputs: down-counter with a `done` flag.
  - Instantiated once and shared by all timed states.

Test Plan (T_PWRUP=20, T_AS=2, T_PW=3, T_H=2, T_SHORT=8, T_LONG=30):
- Reset release, no requests:
  - After 20 cycles, exactly 6 E pulses appear, each 3 cycles wide, with RS=0 and DB = 38, 38, 38, 0C, 01, 06.
  - The 01 pulse is followed by a 30-cycle wait, the others by 8.
  - Then INIT_DONE=1 and LCD_RDY=1.
- After init, ENB=1 for 2 cycles with OPER=01, DATA=0x52:
  - One pulse with RS=1, DB=0x52.
  - LCD_RDY is low for exactly 2+3+2+8 cycles plus the capture cycle.
- ENB held high across 5 consecutive bytes "1234R" fed by a sequencer model that advances on LCD_RDY: exactly 5 pulses in order, no duplicates.
- OPER=10, DATA=0x02 -> RS=0 pulse followed by a 30-cycle wait; DATA=0x0C -> 8-cycle wait.
- OPER=11 in IDLE -> INIT_DONE falls, full 6-write init sequence replays, then LCD_RDY=1. ENB=1 with OPER=00 -> no pulse.
- RST asserted during PULSE:
  - LCD_E=0 asynchronously and all outputs 0.
  - After release, the 20-cycle power-up wait restarts and no stale write occurs.
